// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants, bus types and the fetch FSM encoding for the fetch unit.
// Pure declarations; no timing or flow-control behaviour lives here.
package pc_fetch_unit_pkg;

    localparam logic RST_ENABLE  = 1'b0;
    localparam logic JUMP_ENABLE = 1'b1;
    localparam logic HOLD_ENABLE = 1'b1;

    localparam logic [31:0] INST_NOP  = 32'h0000_0001;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef logic [31:0] sram_bus_t;
    typedef logic [31:0] sram_addr_t;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        sram_addr_t addr;
        sram_bus_t  inst;
    } inst_entry_t;

    function automatic sram_addr_t word_align(input sram_addr_t a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from registered storage.
// Zero-latency head; caller guarantees no push when full and no pop when empty.
module fetch_fifo
    import pc_fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push && !flush && rst != RST_ENABLE) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the PC, issues req/gnt/rvalid SRAM reads and queues {addr,inst} for IF/ID.
// gnt at N, rvalid at N+1 -> inst_valid_o at N+2; issue stalls when queue+in-flight reach FIFO_DEPTH.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        dm_halt_req_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        halted_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state;
    sram_addr_t   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] inst_count;
    logic [CW-1:0] tag_count;
    logic [CW:0]   budget_used;

    logic        jump;
    logic        hold;
    logic        room;
    logic        grant;
    logic        rvalid_eff;
    logic        keep_word;
    logic        pop;
    sram_addr_t  tag_head;
    inst_entry_t inst_head;
    inst_entry_t inst_push_dat;

    assign jump = (jump_flag_i == JUMP_ENABLE);
    assign hold = (hold_flag_i == HOLD_ENABLE);

    // Discarded reads still occupy budget so the queue can never overflow.
    assign budget_used = {1'b0, inst_count} + {1'b0, outstanding};
    assign room        = budget_used < (CW+1)'(FIFO_DEPTH);

    assign mem_req_o  = (rst != RST_ENABLE) && (state == FETCH_RUN) && !dm_halt_req_i
                        && !jump && room;
    assign mem_addr_o = pc;
    assign grant      = mem_req_o && mem_gnt_i;

    // A response with nothing in flight is a leftover from before reset.
    assign rvalid_eff = mem_rvalid_i && (outstanding != '0);
    assign keep_word  = rvalid_eff && (discard == '0) && !jump && (tag_count != '0);

    assign inst_push_dat = '{addr: tag_head, inst: mem_rdata_i};

    assign inst_valid_o = (inst_count != '0);
    assign pop          = inst_valid_o && !hold && !jump && !dm_halt_req_i;
    assign inst_o       = inst_valid_o ? inst_head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? inst_head.addr : ZERO_WORD;
    assign halted_o     = (state == FETCH_HALT) && (outstanding == '0);

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump),
        .push      (grant),
        .push_data (pc),
        .pop       (keep_word),
        .head_data (tag_head),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(inst_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump),
        .push      (keep_word),
        .push_data (inst_push_dat),
        .pop       (pop),
        .head_data (inst_head),
        .count     (inst_count)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case (state)
                FETCH_RUN:  if (dm_halt_req_i)  state <= FETCH_HALT;
                FETCH_HALT: if (!dm_halt_req_i) state <= FETCH_RUN;
                default:    state <= FETCH_RUN;
            endcase

            if (jump) begin
                pc <= word_align(jump_addr_i);
            end else if (grant) begin
                pc <= pc + 32'd4;
            end

            case ({grant, rvalid_eff})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            // Every read still in flight at a jump belongs to the old stream.
            if (jump) begin
                discard <= rvalid_eff ? outstanding - CW'(1) : outstanding;
            end else if (rvalid_eff && discard != '0) begin
                discard <= discard - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench: SRAM responder, directed scenarios, then randomized hold/jump/halt traffic.
module tb_pc_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_i;
    logic        dm_halt_req_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        halted_o;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .dm_halt_req_i (dm_halt_req_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .halted_o      (halted_o)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int consumed = 0;

    int gnt_pct = 100;
    int dly_min = 1;
    int dly_max = 1;
    bit stray = 1'b0;
    bit rv_real = 1'b0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected consumption stream: sequential words from a (re)start address.
    task automatic sb_restart(input logic [31:0] a);
        exp_q.delete();
        for (int i = 0; i < 1024; i++) exp_q.push_back(a + 32'(i * 4));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SRAM responder: in-order rvalid at the due cycle; reset drops everything in flight.
    initial begin : mem_model
        bit rs;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            rs = rst;
            #2;
            if (!rs) begin
                pend_addr.delete();
                pend_due.delete();
            end
            rv_real      = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (stray && rst) begin
                mem_rvalid_i = 1'b1;
                stray        = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_addr[0] ^ KEY;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                rv_real = 1'b1;
            end
            mem_gnt_i = ($urandom_range(99) < gnt_pct);
        end
    end

    // Monitor: PC model, issue gating, halt status, and the consumed-instruction scoreboard.
    bit          p_live = 1'b0;
    bit          p_rstlow = 1'b0;
    bit          p_grant = 1'b0;
    bit          p_jump = 1'b0;
    bit          p_halt = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_jaddr = '0;

    always @(negedge clk) begin : monitor
        int          pd;
        int          due;
        logic [31:0] ea;
        logic [31:0] e;
        if (rst === 1'b1) begin
            pd = pend_addr.size() + (rv_real ? 1 : 0);
            if (p_rstlow) begin
                chk("pc_after_reset", mem_addr_o, RESET_PC);
            end else if (p_live) begin
                ea = p_jump ? (p_jaddr & 32'hFFFF_FFFC) : (p_grant ? p_addr + 32'd4 : p_addr);
                chk("pc_track", mem_addr_o, ea);
            end
            if (jump_flag_i || dm_halt_req_i || p_halt) chk("req_blocked", 32'(mem_req_o), 32'd0);
            chk("budget", 32'(pd <= DEPTH), 32'd1);
            chk("halted", 32'(halted_o), 32'(p_halt && pd == 0));
            if (!inst_valid_o) begin
                chk("idle_inst", inst_o, NOP);
                chk("idle_addr", inst_addr_o, 32'd0);
            end else if (!hold_flag_i && !jump_flag_i && !dm_halt_req_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got addr %h, expected nothing pending", inst_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_addr", inst_addr_o, e);
                    chk("sb_inst", inst_o, e ^ KEY);
                    consumed++;
                end
            end
            if (mem_req_o && mem_gnt_i) begin
                due = cyc + int'($urandom_range(dly_max, dly_min));
                if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
                pend_addr.push_back(mem_addr_o);
                pend_due.push_back(due);
            end
        end
        p_live   = (rst === 1'b1);
        p_rstlow = (rst !== 1'b1);
        p_grant  = (rst === 1'b1) && mem_req_o && mem_gnt_i;
        p_jump   = (rst === 1'b1) && jump_flag_i;
        p_jaddr  = jump_addr_i;
        p_addr   = mem_addr_o;
        p_halt   = (rst === 1'b1) && dm_halt_req_i;
    end

    task automatic do_reset(input bit check_state);
        rst           = 1'b0;
        hold_flag_i   = 1'b0;
        jump_flag_i   = 1'b0;
        dm_halt_req_i = 1'b0;
        jump_addr_i   = '0;
        sb_restart(RESET_PC);
        step();
        step();
        if (check_state) begin
            @(negedge clk);
            chk("rst_req", 32'(mem_req_o), 32'd0);
            chk("rst_valid", 32'(inst_valid_o), 32'd0);
            chk("rst_inst", inst_o, NOP);
            chk("rst_addr", inst_addr_o, 32'd0);
            chk("rst_halted", 32'(halted_o), 32'd0);
        end
        step();
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stim
        int halt_left;
        rst           = 1'b0;
        hold_flag_i   = 1'b0;
        jump_flag_i   = 1'b0;
        dm_halt_req_i = 1'b0;
        jump_addr_i   = '0;

        // Back-to-back fetch from reset, one-cycle responses.
        gnt_pct = 100; dly_min = 1; dly_max = 1;
        do_reset(1'b1);
        @(negedge clk);
        chk("t1_req0", 32'(mem_req_o), 32'd1);
        chk("t1_addr0", mem_addr_o, 32'h0);
        @(negedge clk);
        chk("t1_addr4", mem_addr_o, 32'h4);
        @(negedge clk);
        chk("t1_valid", 32'(inst_valid_o), 32'd1);
        chk("t1_iaddr", inst_addr_o, 32'h0);
        chk("t1_inst", inst_o, KEY);
        repeat (20) step();

        // Hold for five cycles: budget fills, head stays put.
        do_reset(1'b0);
        hold_flag_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_valid", 32'(inst_valid_o), 32'd1);
        chk("t2_head_a", inst_addr_o, 32'h0);
        @(negedge clk);
        chk("t2_head_b", inst_addr_o, 32'h0);
        chk("t2_inst_b", inst_o, KEY);
        @(negedge clk);
        chk("t2_req_full", 32'(mem_req_o), 32'd0);
        chk("t2_head_c", inst_addr_o, 32'h0);
        step();
        hold_flag_i = 1'b0;
        repeat (20) step();

        // Jump with two reads in flight: both responses must be dropped.
        dly_min = 3; dly_max = 3;
        do_reset(1'b0);
        step();
        step();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0102;
        sb_restart(32'h0000_0100);
        step();
        jump_flag_i = 1'b0;
        @(negedge clk);
        chk("t3_valid_cleared", 32'(inst_valid_o), 32'd0);
        for (int i = 0; i < 20 && !inst_valid_o; i++) @(negedge clk);
        chk("t3_valid", 32'(inst_valid_o), 32'd1);
        chk("t3_first", inst_addr_o, 32'h0000_0100);
        repeat (15) step();

        // Grant withheld for three cycles.
        dly_min = 1; dly_max = 1; gnt_pct = 0;
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_req", 32'(mem_req_o), 32'd1);
            chk("t4_addr", mem_addr_o, 32'h0);
        end
        step();
        gnt_pct = 100;
        repeat (15) step();

        // Halt with one read outstanding.
        dly_min = 3; dly_max = 3;
        do_reset(1'b0);
        step();
        dm_halt_req_i = 1'b1;
        @(negedge clk);
        chk("t5_req_off", 32'(mem_req_o), 32'd0);
        for (int i = 0; i < 10 && !halted_o; i++) @(negedge clk);
        chk("t5_halted", 32'(halted_o), 32'd1);
        repeat (4) @(negedge clk);
        chk("t5_kept_valid", 32'(inst_valid_o), 32'd1);
        chk("t5_kept_addr", inst_addr_o, 32'h0);
        step();
        dm_halt_req_i = 1'b0;
        step();
        @(negedge clk);
        chk("t5_resume_req", 32'(mem_req_o), 32'd1);
        chk("t5_resume_addr", mem_addr_o, 32'h4);
        repeat (10) step();

        // Reset mid-stream with two reads in flight, stray rvalid afterwards.
        for (int i = 0; i < 30 && pend_addr.size() != 2; i++) step();
        chk("t6_inflight", 32'(pend_addr.size()), 32'd2);
        stray = 1'b1;
        do_reset(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_stray_ignored", 32'(inst_valid_o), 32'd0);
        repeat (15) step();

        // Randomized traffic.
        gnt_pct = 70; dly_min = 1; dly_max = 4;
        halt_left = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            hold_flag_i = ($urandom_range(99) < 30);
            if (halt_left == 0 && $urandom_range(99) < 3) halt_left = int'($urandom_range(8, 3));
            dm_halt_req_i = (halt_left > 0);
            if (halt_left > 0) halt_left--;
            if (!jump_flag_i && $urandom_range(99) < 5) begin
                jump_flag_i = 1'b1;
                jump_addr_i = $urandom;
                sb_restart(jump_addr_i & 32'hFFFF_FFFC);
            end else begin
                jump_flag_i = 1'b0;
            end
        end
        step();
        hold_flag_i   = 1'b0;
        jump_flag_i   = 1'b0;
        dm_halt_req_i = 1'b0;
        repeat (10) step();
        chk("liveness", 32'(consumed > 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
